// File: rtl/bip_program_loader_pkg.sv
// rtl/bip_program_loader_pkg.sv - shared constants and state type for the BIP program loader
//
// Purpose: default widths, the HLT opcode and the loader FSM state encoding.
// Ports:   none (package).
package bip_program_loader_pkg;

    localparam int NBITS_D_DEF    = 16;
    localparam int NBITS_ADDR_DEF = 11;
    localparam int OPCODE_DEF     = 5;
    localparam int NBITS_BYTE_DEF = 8;

    localparam logic [OPCODE_DEF-1:0] OP_HLT = 5'b00000;

    typedef enum logic [1:0] {
        ST_LOAD_HI = 2'd0,
        ST_LOAD_LO = 2'd1,
        ST_RUN     = 2'd2,
        ST_HALT    = 2'd3
    } state_t;

endpackage

// File: rtl/bip_program_loader_if.sv
// rtl/bip_program_loader_if.sv - UART byte stream and instruction fetch bus of the program loader
//
// Purpose: bundles the RX byte handshake and the PC -> instruction fetch path.
// Signals: i_rx_data/i_rx_done (byte strobe from UART), i_addr (PC from control unit),
//          o_instruction (word served to control unit).
// Modports: master = UART + control unit side, slave = loader side.
interface bip_program_loader_if #(
    parameter int NBITS_D    = 16,
    parameter int NBITS_ADDR = 11,
    parameter int NBITS_BYTE = 8
);
    logic [NBITS_BYTE-1:0] i_rx_data;
    logic                  i_rx_done;
    logic [NBITS_ADDR-1:0] i_addr;
    logic [NBITS_D-1:0]    o_instruction;

    modport master (
        output i_rx_data,
        output i_rx_done,
        output i_addr,
        input  o_instruction
    );

    modport slave (
        input  i_rx_data,
        input  i_rx_done,
        input  i_addr,
        output o_instruction
    );
endinterface

// File: rtl/bip_program_loader_program_memory.sv
// rtl/bip_program_loader_program_memory.sv - DEPTH x NBITS_D program store, sync write / async read
//
// Purpose: instruction storage for the loader; contents are never reset.
// Ports:   clk; we/waddr/wdata (write on rising edge); raddr -> rdata (combinational).
module program_memory #(
    parameter int NBITS_D    = 16,
    parameter int NBITS_ADDR = 11
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [NBITS_ADDR-1:0] waddr,
    input  logic [NBITS_D-1:0]    wdata,
    input  logic [NBITS_ADDR-1:0] raddr,
    output logic [NBITS_D-1:0]    rdata
);
    localparam int DEPTH = 2 ** NBITS_ADDR;

    logic [NBITS_D-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/bip_program_loader.sv
// rtl/bip_program_loader.sv - program load/run front end feeding the BIP control unit
//
// Purpose: assembles UART bytes (high byte first) into instructions, stores them,
//          then serves mem[PC] while running and stops on HLT.
// Ports:   i_clock, i_reset (async, active low); bus (slave: rx byte strobe, PC in,
//          instruction out); i_clear / i_restart (sync pulses); o_cpu_reset (active high
//          reset to control unit), o_halt, o_loading, o_prog_len (words loaded).
module bip_program_loader
    import bip_program_loader_pkg::*;
#(
    parameter int NBITS_D    = NBITS_D_DEF,
    parameter int NBITS_ADDR = NBITS_ADDR_DEF,
    parameter int OPCODE     = OPCODE_DEF,
    parameter int NBITS_BYTE = NBITS_BYTE_DEF
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    bip_program_loader_if.slave   bus,
    input  logic                  i_clear,
    input  logic                  i_restart,
    output logic                  o_cpu_reset,
    output logic                  o_halt,
    output logic                  o_loading,
    output logic [NBITS_ADDR:0]   o_prog_len
);
    localparam int DEPTH = 2 ** NBITS_ADDR;
    localparam logic [NBITS_ADDR-1:0] LAST_ADDR = NBITS_ADDR'(DEPTH - 1);
    localparam logic [NBITS_ADDR-1:0] ADDR_ONE  = NBITS_ADDR'(1);
    localparam logic [NBITS_ADDR:0]   LEN_ONE   = (NBITS_ADDR + 1)'(1);

    state_t                state, state_n;
    logic [NBITS_ADDR-1:0] wptr, wptr_n;
    logic [NBITS_BYTE-1:0] hi_byte, hi_byte_n;
    logic [NBITS_ADDR:0]   prog_len, prog_len_n;
    logic                  run_first, run_first_n;

    logic                  mem_we;
    logic [NBITS_D-1:0]    word;
    logic [NBITS_D-1:0]    rdata;
    logic [NBITS_D-1:0]    instr;

    assign word = {hi_byte, bus.i_rx_data};

    program_memory #(
        .NBITS_D    (NBITS_D),
        .NBITS_ADDR (NBITS_ADDR)
    ) u_mem (
        .clk   (i_clock),
        .we    (mem_we),
        .waddr (wptr),
        .wdata (word),
        .raddr (bus.i_addr),
        .rdata (rdata)
    );

    // Addresses past the loaded program read as 0, i.e. HLT with operand 0,
    // so a runaway PC stops the CPU instead of executing stale memory.
    assign instr = (state == ST_RUN && {1'b0, bus.i_addr} < prog_len) ? rdata : '0;

    assign bus.o_instruction = instr;
    assign o_prog_len        = prog_len;
    assign o_halt            = (state == ST_HALT);
    assign o_loading         = (state == ST_LOAD_HI) || (state == ST_LOAD_LO);
    assign o_cpu_reset       = !(state == ST_RUN && !run_first);

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state     <= ST_LOAD_HI;
            wptr      <= '0;
            hi_byte   <= '0;
            prog_len  <= '0;
            run_first <= 1'b0;
        end else begin
            state     <= state_n;
            wptr      <= wptr_n;
            hi_byte   <= hi_byte_n;
            prog_len  <= prog_len_n;
            run_first <= run_first_n;
        end
    end

    always_comb begin
        state_n     = state;
        wptr_n      = wptr;
        hi_byte_n   = hi_byte;
        prog_len_n  = prog_len;
        run_first_n = run_first;
        mem_we      = 1'b0;

        if (i_clear) begin
            state_n     = ST_LOAD_HI;
            wptr_n      = '0;
            prog_len_n  = '0;
            run_first_n = 1'b0;
        end else begin
            unique case (state)
                ST_LOAD_HI: begin
                    if (bus.i_rx_done) begin
                        hi_byte_n = bus.i_rx_data;
                        state_n   = ST_LOAD_LO;
                    end
                end
                ST_LOAD_LO: begin
                    if (bus.i_rx_done) begin
                        mem_we     = 1'b1;
                        prog_len_n = prog_len + LEN_ONE;
                        // The last slot ends the load; wptr is held there so it never wraps.
                        if (word == '0 || wptr == LAST_ADDR) begin
                            state_n     = ST_RUN;
                            run_first_n = 1'b1;
                        end else begin
                            wptr_n  = wptr + ADDR_ONE;
                            state_n = ST_LOAD_HI;
                        end
                    end
                end
                ST_RUN: begin
                    // The first RUN cycle only zeroes the control PC; HLT is not
                    // evaluated until the control unit is out of reset.
                    if (run_first) begin
                        run_first_n = 1'b0;
                    end else if (instr[NBITS_D-1 -: OPCODE] == OP_HLT) begin
                        state_n = ST_HALT;
                    end
                end
                ST_HALT: begin
                    if (i_restart) begin
                        state_n     = ST_RUN;
                        run_first_n = 1'b1;
                    end
                end
                default: state_n = ST_LOAD_HI;
            endcase
        end
    end

endmodule
